// File: rtl/e203_eai_csr_resp_pkg.sv
// Shared definitions for the EAI CSR responder: CSR indices, register bit
// positions and the engine-tracking FSM encoding.
package e203_eai_csr_resp_pkg;

  localparam logic [7:0]  E203_EAI_CSR_PAGE  = 8'hE0;
  localparam logic [11:0] E203_EAI_CSR_ECTL  = 12'hE00;
  localparam logic [11:0] E203_EAI_CSR_ESTAT = 12'hE01;
  localparam logic [11:0] E203_EAI_CSR_EARG0 = 12'hE02;
  localparam logic [11:0] E203_EAI_CSR_EARG1 = 12'hE03;
  localparam logic [11:0] E203_EAI_CSR_ERES  = 12'hE04;
  localparam logic [11:0] E203_EAI_CSR_ECYC  = 12'hE05;

  localparam int ECTL_START    = 0;
  localparam int ECTL_IE       = 1;
  localparam int ECTL_MODE_LSB = 4;

  localparam int ESTAT_BUSY = 0;
  localparam int ESTAT_DONE = 1;
  localparam int ESTAT_ERR  = 2;
  localparam int ESTAT_OVR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } eai_state_e;

endpackage

// File: rtl/e203_eai_csr_resp_if.sv
// EAI CSR access channel between the EXU CSR path (master) and the responder (slave).
// Handshake: an access fires on a cycle where eai_csr_valid && eai_csr_ready; writes commit
// at that clock edge, rdata is meaningful only in a firing cycle and is 0 otherwise.
interface e203_eai_csr_resp_if;
  logic        eai_csr_valid;
  logic        eai_csr_ready;
  logic [11:0] eai_csr_addr;
  logic        eai_csr_wr;
  logic [31:0] eai_csr_wdata;
  logic [31:0] eai_csr_rdata;

  modport master (
    output eai_csr_valid, eai_csr_addr, eai_csr_wr, eai_csr_wdata,
    input  eai_csr_ready, eai_csr_rdata
  );

  modport slave (
    input  eai_csr_valid, eai_csr_addr, eai_csr_wr, eai_csr_wdata,
    output eai_csr_ready, eai_csr_rdata
  );
endinterface

// File: rtl/e203_eai_csr_resp.sv
// EAI CSR responder: small CSR bank for an attached engine, same-cycle read mux,
// and an IDLE/LAUNCH/RUN FSM that launches the engine and records its completion.
module e203_eai_csr_resp
  import e203_eai_csr_resp_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MODE_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  e203_eai_csr_resp_if.slave   csr,
  output logic                 eng_start_valid,
  input  logic                 eng_start_ready,
  output logic [MODE_W-1:0]    eng_mode,
  output logic [31:0]          eng_arg0,
  output logic [31:0]          eng_arg1,
  input  logic                 eng_done,
  input  logic                 eng_err,
  input  logic [31:0]          eng_result,
  output logic                 eai_irq,
  output eai_state_e           dbg_state
);

  eai_state_e          state;
  logic                ie;
  logic [MODE_W-1:0]   mode;
  logic                done;
  logic                err;
  logic                ovr;
  logic [31:0]         earg0;
  logic [31:0]         earg1;
  logic [31:0]         eres;
  logic [CNT_W-1:0]    ecyc;

  logic                fire;
  logic                page_hit;
  logic                wr_fire;
  logic [3:0]          idx;
  logic [31:0]         rdata;

  // Ready depends only on registered state so the initiator never sees a comb loop.
  assign csr.eai_csr_ready = (state != ST_LAUNCH);
  assign fire     = csr.eai_csr_valid && csr.eai_csr_ready;
  assign page_hit = (csr.eai_csr_addr[11:4] == E203_EAI_CSR_PAGE);
  assign wr_fire  = fire && page_hit && csr.eai_csr_wr;
  assign idx      = csr.eai_csr_addr[3:0];

  always_comb begin
    rdata = '0;
    if (fire && page_hit) begin
      case (idx)
        E203_EAI_CSR_ECTL[3:0]:  rdata = (32'(mode) << ECTL_MODE_LSB) | (32'(ie) << ECTL_IE);
        E203_EAI_CSR_ESTAT[3:0]: rdata = (32'(ovr)  << ESTAT_OVR)  | (32'(err) << ESTAT_ERR) |
                                         (32'(done) << ESTAT_DONE) |
                                         (32'(state != ST_IDLE) << ESTAT_BUSY);
        E203_EAI_CSR_EARG0[3:0]: rdata = earg0;
        E203_EAI_CSR_EARG1[3:0]: rdata = earg1;
        E203_EAI_CSR_ERES[3:0]:  rdata = eres;
        E203_EAI_CSR_ECYC[3:0]:  rdata = 32'(ecyc);
        default:                 rdata = '0;
      endcase
    end
  end

  assign csr.eai_csr_rdata = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ie    <= 1'b0;
      mode  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      ovr   <= 1'b0;
      earg0 <= '0;
      earg1 <= '0;
      eres  <= '0;
      ecyc  <= '0;
    end else begin
      if ((state != ST_IDLE) && (ecyc != '1)) begin
        ecyc <= ecyc + CNT_W'(1);
      end

      case (state)
        ST_LAUNCH: if (eng_start_ready) state <= ST_RUN;
        ST_RUN:    if (eng_done)        state <= ST_IDLE;
        default:   ;
      endcase

      if (wr_fire) begin
        case (idx)
          E203_EAI_CSR_ECTL[3:0]: begin
            ie   <= csr.eai_csr_wdata[ECTL_IE];
            mode <= csr.eai_csr_wdata[ECTL_MODE_LSB +: MODE_W];
            if (csr.eai_csr_wdata[ECTL_START]) begin
              if (state == ST_IDLE) begin
                state <= ST_LAUNCH;
                done  <= 1'b0;
                err   <= 1'b0;
                ecyc  <= '0;
              end else begin
                ovr <= 1'b1;
              end
            end
          end
          E203_EAI_CSR_ESTAT[3:0]: begin
            done <= csr.eai_csr_wdata[ESTAT_DONE];
            err  <= csr.eai_csr_wdata[ESTAT_ERR];
            ovr  <= csr.eai_csr_wdata[ESTAT_OVR];
          end
          E203_EAI_CSR_EARG0[3:0]: earg0 <= csr.eai_csr_wdata;
          E203_EAI_CSR_EARG1[3:0]: earg1 <= csr.eai_csr_wdata;
          default: ;
        endcase
      end

      // Completion comes last so it overrides a same-cycle software clear.
      if ((state == ST_RUN) && eng_done) begin
        eres <= eng_result;
        done <= 1'b1;
        err  <= eng_err;
      end
    end
  end

  assign eng_start_valid = (state == ST_LAUNCH);
  assign eng_mode        = mode;
  assign eng_arg0        = earg0;
  assign eng_arg1        = earg1;
  assign eai_irq         = ie && done;
  assign dbg_state       = state;

endmodule

// File: tb/tb_e203_eai_csr_resp.sv
// Directed bench for e203_eai_csr_resp: CSR bank access, launch/run/complete flow,
// overrun, set-vs-clear priority and asynchronous reset mid-run.
module tb_e203_eai_csr_resp;
  import e203_eai_csr_resp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        eng_start_valid;
  logic        eng_start_ready;
  logic [3:0]  eng_mode;
  logic [31:0] eng_arg0;
  logic [31:0] eng_arg1;
  logic        eng_done;
  logic        eng_err;
  logic [31:0] eng_result;
  logic        eai_irq;
  eai_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rd;

  e203_eai_csr_resp_if csr_if ();

  e203_eai_csr_resp #(.CNT_W(32), .MODE_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr             (csr_if.slave),
    .eng_start_valid (eng_start_valid),
    .eng_start_ready (eng_start_ready),
    .eng_mode        (eng_mode),
    .eng_arg0        (eng_arg0),
    .eng_arg1        (eng_arg1),
    .eng_done        (eng_done),
    .eng_err         (eng_err),
    .eng_result      (eng_result),
    .eai_irq         (eai_irq),
    .dbg_state       (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_if.eai_csr_valid = 1'b1;
    csr_if.eai_csr_wr    = 1'b1;
    csr_if.eai_csr_addr  = addr;
    csr_if.eai_csr_wdata = data;
    cycle();
    csr_if.eai_csr_valid = 1'b0;
    csr_if.eai_csr_wr    = 1'b0;
    csr_if.eai_csr_wdata = '0;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] data);
    csr_if.eai_csr_valid = 1'b1;
    csr_if.eai_csr_wr    = 1'b0;
    csr_if.eai_csr_addr  = addr;
    #1;
    data = csr_if.eai_csr_rdata;
    cycle();
    csr_if.eai_csr_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    csr_if.eai_csr_valid = 1'b0;
    csr_if.eai_csr_wr    = 1'b0;
    csr_if.eai_csr_addr  = '0;
    csr_if.eai_csr_wdata = '0;
    eng_start_ready = 1'b0;
    eng_done   = 1'b0;
    eng_err    = 1'b0;
    eng_result = '0;
    repeat (3) cycle();

    chk("rst_ready", 32'(csr_if.eai_csr_ready), 32'd1);
    chk("rst_start_valid", 32'(eng_start_valid), 32'd0);
    chk("rst_irq", 32'(eai_irq), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    cycle();

    // Register bank access
    csr_write(E203_EAI_CSR_EARG0, 32'h1234_5678);
    csr_read(E203_EAI_CSR_EARG0, rd);
    chk("earg0_rd", rd, 32'h1234_5678);
    chk("eng_arg0", eng_arg0, 32'h1234_5678);
    csr_if.eai_csr_addr = E203_EAI_CSR_EARG0;
    #1;
    chk("rdata_no_valid", csr_if.eai_csr_rdata, 32'h0);
    csr_read(12'hE0F, rd);
    chk("unmapped_rd", rd, 32'h0);
    csr_write(12'hE0F, 32'hFFFF_FFFF);
    csr_read(12'hE0F, rd);
    chk("unmapped_wr", rd, 32'h0);
    csr_read(E203_EAI_CSR_EARG1, rd);
    chk("earg1_untouched", rd, 32'h0);
    csr_write(E203_EAI_CSR_EARG1, 32'hA5A5_0F0F);
    csr_read(E203_EAI_CSR_EARG1, rd);
    chk("earg1_rd", rd, 32'hA5A5_0F0F);
    chk("eng_arg1", eng_arg1, 32'hA5A5_0F0F);

    // Launch held off by engine for 3 cycles, accepted on the 4th
    eng_start_ready = 1'b0;
    csr_write(E203_EAI_CSR_ECTL, 32'h33);
    chk("l1_ready", 32'(csr_if.eai_csr_ready), 32'd0);
    chk("l1_start_valid", 32'(eng_start_valid), 32'd1);
    chk("l1_mode", 32'(eng_mode), 32'd3);
    chk("l1_state", 32'(dbg_state), 32'(ST_LAUNCH));
    csr_if.eai_csr_valid = 1'b1;
    csr_if.eai_csr_addr  = E203_EAI_CSR_EARG1;
    #1;
    chk("l1_rdata_blocked", csr_if.eai_csr_rdata, 32'h0);
    csr_if.eai_csr_valid = 1'b0;
    cycle();
    chk("l2_ready", 32'(csr_if.eai_csr_ready), 32'd0);
    cycle();
    chk("l3_ready", 32'(csr_if.eai_csr_ready), 32'd0);
    chk("l3_start_valid", 32'(eng_start_valid), 32'd1);
    cycle();
    chk("l4_ready", 32'(csr_if.eai_csr_ready), 32'd0);
    eng_start_ready = 1'b1;
    cycle();
    eng_start_ready = 1'b0;
    chk("run_ready", 32'(csr_if.eai_csr_ready), 32'd1);
    chk("run_start_valid", 32'(eng_start_valid), 32'd0);
    chk("run_state", 32'(dbg_state), 32'(ST_RUN));
    csr_read(E203_EAI_CSR_ECTL, rd);
    chk("run_ectl", rd, 32'h32);
    csr_read(E203_EAI_CSR_ESTAT, rd);
    chk("run_estat_busy", rd, 32'h1);
    csr_read(E203_EAI_CSR_ECYC, rd);
    chk("run_ecyc_mid", rd, 32'd6);
    repeat (6) cycle();
    eng_done = 1'b1; eng_result = 32'hCAFE; eng_err = 1'b0;
    cycle();
    eng_done = 1'b0;
    chk("done1_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("done1_irq", 32'(eai_irq), 32'd1);
    csr_read(E203_EAI_CSR_ERES, rd);
    chk("done1_eres", rd, 32'hCAFE);
    csr_read(E203_EAI_CSR_ESTAT, rd);
    chk("done1_estat", rd, 32'h2);
    csr_read(E203_EAI_CSR_ECYC, rd);
    chk("done1_ecyc", rd, 32'd14);

    // Immediate accept, overrun start during RUN, error completion
    eng_start_ready = 1'b1;
    csr_write(E203_EAI_CSR_ECTL, 32'h33);
    chk("l_irq_cleared", 32'(eai_irq), 32'd0);
    chk("l_start_valid", 32'(eng_start_valid), 32'd1);
    cycle();
    eng_start_ready = 1'b0;
    csr_write(E203_EAI_CSR_ECTL, 32'h53);
    chk("ovr_no_relaunch", 32'(eng_start_valid), 32'd0);
    chk("ovr_state", 32'(dbg_state), 32'(ST_RUN));
    chk("ovr_mode", 32'(eng_mode), 32'd5);
    csr_write(E203_EAI_CSR_EARG0, 32'hDEAD_BEEF);
    chk("run_arg0_wr", eng_arg0, 32'hDEAD_BEEF);
    csr_read(E203_EAI_CSR_ESTAT, rd);
    chk("ovr_estat", rd, 32'h9);
    csr_read(E203_EAI_CSR_ECTL, rd);
    chk("ovr_ectl", rd, 32'h52);
    repeat (5) cycle();
    eng_done = 1'b1; eng_result = 32'hBEEF; eng_err = 1'b1;
    cycle();
    eng_done = 1'b0; eng_err = 1'b0;
    chk("done2_irq", 32'(eai_irq), 32'd1);
    csr_read(E203_EAI_CSR_ESTAT, rd);
    chk("done2_estat", rd, 32'hE);
    csr_read(E203_EAI_CSR_ECYC, rd);
    chk("done2_ecyc", rd, 32'd11);
    csr_read(E203_EAI_CSR_ERES, rd);
    chk("done2_eres", rd, 32'hBEEF);
    csr_write(E203_EAI_CSR_ESTAT, 32'h0);
    csr_read(E203_EAI_CSR_ESTAT, rd);
    chk("estat_cleared", rd, 32'h0);
    chk("irq_cleared", 32'(eai_irq), 32'd0);

    // Completion wins over same-cycle ESTAT clear; done in IDLE ignored
    eng_start_ready = 1'b1;
    csr_write(E203_EAI_CSR_ECTL, 32'h03);
    cycle();
    eng_start_ready = 1'b0;
    chk("l3_mode0", 32'(eng_mode), 32'd0);
    eng_done = 1'b1; eng_result = 32'h77; eng_err = 1'b0;
    csr_write(E203_EAI_CSR_ESTAT, 32'h0);
    eng_done = 1'b0;
    chk("race_state", 32'(dbg_state), 32'(ST_IDLE));
    csr_read(E203_EAI_CSR_ESTAT, rd);
    chk("race_done_wins", rd, 32'h2);
    chk("race_irq", 32'(eai_irq), 32'd1);
    eng_done = 1'b1; eng_result = 32'h99; eng_err = 1'b1;
    cycle();
    eng_done = 1'b0; eng_err = 1'b0;
    csr_read(E203_EAI_CSR_ERES, rd);
    chk("idle_done_eres", rd, 32'h77);
    csr_read(E203_EAI_CSR_ESTAT, rd);
    chk("idle_done_estat", rd, 32'h2);

    // Done during LAUNCH ignored, then reset mid-RUN
    csr_write(E203_EAI_CSR_ECTL, 32'h33);
    eng_done = 1'b1; eng_result = 32'h11;
    cycle();
    eng_done = 1'b0;
    chk("launch_done_ign", 32'(dbg_state), 32'(ST_LAUNCH));
    eng_start_ready = 1'b1;
    cycle();
    eng_start_ready = 1'b0;
    repeat (3) cycle();
    chk("pre_rst_state", 32'(dbg_state), 32'(ST_RUN));
    chk("pre_rst_mode", 32'(eng_mode), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 32'(csr_if.eai_csr_ready), 32'd1);
    chk("mrst_start_valid", 32'(eng_start_valid), 32'd0);
    chk("mrst_irq", 32'(eai_irq), 32'd0);
    chk("mrst_mode", 32'(eng_mode), 32'd0);
    chk("mrst_arg0", eng_arg0, 32'h0);
    chk("mrst_arg1", eng_arg1, 32'h0);
    chk("mrst_state", 32'(dbg_state), 32'(ST_IDLE));
    cycle();
    rst_n = 1'b1;
    eng_done = 1'b1; eng_result = 32'h55; eng_err = 1'b1;
    cycle();
    eng_done = 1'b0; eng_err = 1'b0;
    csr_read(E203_EAI_CSR_ESTAT, rd);
    chk("post_rst_estat", rd, 32'h0);
    csr_read(E203_EAI_CSR_ERES, rd);
    chk("post_rst_eres", rd, 32'h0);
    csr_read(E203_EAI_CSR_ECYC, rd);
    chk("post_rst_ecyc", rd, 32'h0);
    chk("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
